// File: rtl/wb_ips_splitter.sv
// wb_ips_splitter: Wishbone classic slave-side splitter for the user-project IP cluster.
// Decodes wbs_adr_i[SEL_MSB:SEL_LSB] against SLOT_MAP, strobes one downstream slave,
// and returns a registered ack or err to the master (err for unmapped slots and timeouts).
// Optional feature macro: WB_SPLIT_TIMEOUT_EN enables the per-access watchdog counter
// and the sticky timeout_irq_o flag; without it ACTIVE waits for an ack or a cyc drop.
`timescale 1ns/1ps

module wb_ips_splitter #(
    parameter int unsigned NUM_SLAVES   = 4,
    parameter int unsigned SEL_MSB      = 19,
    parameter int unsigned SEL_LSB      = 16,
    parameter logic [NUM_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLOT_MAP = 16'h6420,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] DEFAULT_DATA = 32'hDEADBEEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic                       wbs_err_o,
    output logic [31:0]                wbs_dat_o,
    output logic                       s_cyc_o,
    output logic                       s_we_o,
    output logic [3:0]                 s_sel_o,
    output logic [31:0]                s_adr_o,
    output logic [31:0]                s_dat_o,
    output logic [NUM_SLAVES-1:0]      s_stb_o,
    input  logic [NUM_SLAVES-1:0]      s_ack_i,
    input  logic [NUM_SLAVES*32-1:0]   s_dat_i,
    output logic                       timeout_irq_o,
    input  logic                       timeout_clr_i
);

    localparam int unsigned SW = SEL_MSB - SEL_LSB + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_next;
    logic [NUM_SLAVES-1:0] sel_q, sel_next;
    logic [NUM_SLAVES-1:0] stb_next;
    logic                  ack_next, err_next;
    logic [31:0]           dat_next;

    logic [SW-1:0]         slot;
    logic [NUM_SLAVES-1:0] match_onehot;
    logic                  match_any;
    logic                  req;
    logic                  sel_ack;
    logic [31:0]           sel_data;

`ifdef WB_SPLIT_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_next;
    logic        timeout_hit;
    logic        irq_next;
`else
    logic        unused_timeout_clr;
    assign unused_timeout_clr = timeout_clr_i;
    assign timeout_irq_o      = 1'b0;
`endif

    // Request fields are broadcast unchanged; only the strobe is per-slave.
    assign s_cyc_o = wbs_cyc_i;
    assign s_we_o  = wbs_we_i;
    assign s_sel_o = wbs_sel_i;
    assign s_adr_o = wbs_adr_i;
    assign s_dat_o = wbs_dat_i;

    assign req  = wbs_cyc_i & wbs_stb_i;
    assign slot = wbs_adr_i[SEL_MSB:SEL_LSB];

    // Slot decode; the first (lowest-index) matching field wins on duplicate codes.
    always_comb begin
        match_onehot = '0;
        match_any    = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!match_any && (slot == SLOT_MAP[i*SW +: SW])) begin
                match_onehot[i] = 1'b1;
                match_any       = 1'b1;
            end
        end
    end

    // Ack and read data of the latched slave only; other slaves' acks are ignored.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_data = s_dat_i[i*32 +: 32];
            end
        end
    end

    assign sel_ack = |(s_ack_i & sel_q);

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_next = state_q;
        sel_next   = sel_q;
        stb_next   = '0;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        dat_next   = wbs_dat_o;
`ifdef WB_SPLIT_TIMEOUT_EN
        cnt_next    = cnt_q;
        timeout_hit = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (match_any) begin
                        sel_next   = match_onehot;
                        stb_next   = match_onehot;
                        state_next = ACTIVE;
`ifdef WB_SPLIT_TIMEOUT_EN
                        cnt_next   = '0;
`endif
                    end else begin
                        err_next   = 1'b1;
                        dat_next   = DEFAULT_DATA;
                        state_next = RESP;
                    end
                end
            end
            ACTIVE: begin
                if (!wbs_cyc_i) begin
                    state_next = IDLE;
                end else if (sel_ack) begin
                    ack_next   = 1'b1;
                    dat_next   = sel_data;
                    state_next = RESP;
                end
`ifdef WB_SPLIT_TIMEOUT_EN
                // Counter holds cycles already spent in ACTIVE, so the last
                // allowed cycle is TIMEOUT-1 and err lands at cycle TIMEOUT+1.
                else if (cnt_q == TIMEOUT_LAST) begin
                    err_next    = 1'b1;
                    dat_next    = DEFAULT_DATA;
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
`endif
                else begin
                    stb_next = sel_q;
`ifdef WB_SPLIT_TIMEOUT_EN
                    cnt_next = cnt_q + 16'd1;
`endif
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef WB_SPLIT_TIMEOUT_EN
    // Sticky flag: a new timeout beats a simultaneous clear.
    assign irq_next = timeout_hit | (timeout_irq_o & ~timeout_clr_i);
`endif

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            s_stb_o   <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
`ifdef WB_SPLIT_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_irq_o <= 1'b0;
`endif
        end else begin
            state_q   <= state_next;
            sel_q     <= sel_next;
            s_stb_o   <= stb_next;
            wbs_ack_o <= ack_next;
            wbs_err_o <= err_next;
            wbs_dat_o <= dat_next;
`ifdef WB_SPLIT_TIMEOUT_EN
            cnt_q         <= cnt_next;
            timeout_irq_o <= irq_next;
`endif
        end
    end

endmodule
